// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Pixel-strobed VGA raster timing generator with registered,
//            zero-skew sync/active/strobe outputs. Optional 16-bit frame
//            counter port enabled by macro VGA_FRAME_COUNT_EN.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int HVID   = 640,
  parameter int HFP    = 16,
  parameter int HS     = 96,
  parameter int HBP    = 48,
  parameter int VVID   = 480,
  parameter int VFP    = 10,
  parameter int VS     = 2,
  parameter int VBP    = 29,
  parameter int CW     = 10,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic          clk_25,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int c_HC_MAX = HVID + HFP + HS + HBP;
  localparam int c_VC_MAX = VVID + VFP + VS + VBP;

  localparam logic [CW-1:0] c_X_LAST   = CW'(c_HC_MAX - 1);
  localparam logic [CW-1:0] c_Y_LAST   = CW'(c_VC_MAX - 1);
  localparam logic [CW-1:0] c_X_VID    = CW'(HVID);
  localparam logic [CW-1:0] c_Y_VID    = CW'(VVID);
  localparam logic [CW-1:0] c_HS_START = CW'(HVID + HFP);
  localparam logic [CW-1:0] c_HS_END   = CW'(HVID + HFP + HS);
  localparam logic [CW-1:0] c_VS_START = CW'(VVID + VFP);
  localparam logic [CW-1:0] c_VS_END   = CW'(VVID + VFP + VS);

  generate
    if (HVID == 0 || HFP == 0 || HS == 0 || HBP == 0 ||
        VVID == 0 || VFP == 0 || VS == 0 || VBP == 0 || CW == 0) begin : g_zero_param
      $error("vga_timing_gen: timing parameters and CW must be non-zero");
    end
    if (longint'(c_HC_MAX - 1) > ((longint'(1) << CW) - 1) ||
        longint'(c_VC_MAX - 1) > ((longint'(1) << CW) - 1)) begin : g_cw_too_small
      $error("vga_timing_gen: CW too narrow for the configured raster");
    end
  endgenerate

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic          w_hs_win;
  logic          w_vs_win;
  logic          w_active_next;

  // Every registered output is decoded from the next counter values so that
  // sync/active land on the same edge as the coordinates they describe.
  always_comb begin
    w_x_wrap = (r_x == c_X_LAST);
    w_y_wrap = (r_y == c_Y_LAST);
    w_x_next = w_x_wrap ? '0 : r_x + CW'(1);
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? '0 : r_y + CW'(1);
    end
    w_hs_win      = (w_x_next >= c_HS_START) && (w_x_next < c_HS_END);
    w_vs_win      = (w_y_next >= c_VS_START) && (w_y_next < c_VS_END);
    w_active_next = (w_x_next < c_X_VID) && (w_y_next < c_Y_VID);
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_active      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_hsync       <= w_hs_win ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_win ? VS_POL : ~VS_POL;
      r_active      <= w_active_next;
      r_line_start  <= w_x_wrap;
      r_frame_start <= w_x_wrap && w_y_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Counts on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_frame_count <= '0;
    end else if (pix_en && w_x_wrap && w_y_wrap) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen: three configurations
//            (small, small inverted-polarity, default) against a raster model.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  // Config A: small, active-high syncs
  localparam int A_HVID = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int A_VVID = 5, A_VFP = 1, A_VS = 2, A_VBP = 1;
  // Config B: small, active-low syncs
  localparam int B_HVID = 5, B_HFP = 1, B_HS = 2, B_HBP = 1;
  localparam int B_VVID = 3, B_VFP = 1, B_VS = 1, B_VBP = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    bit   r;
    bit   e;
    int   reps;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic [3:0] px_a, py_a, px_b, py_b;
  logic [9:0] px_d, py_d;
  logic hs_a, vs_a, act_a, ls_a, fs_a;
  logic hs_b, vs_b, act_b, ls_b, fs_b;
  logic hs_d, vs_d, act_d, ls_d, fs_d;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b, fc_d;
`endif

  int total = 0;
  int passed = 0;
  int n = 0;
  bit pulse = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(.HVID(A_HVID), .HFP(A_HFP), .HS(A_HS), .HBP(A_HBP),
                   .VVID(A_VVID), .VFP(A_VFP), .VS(A_VS), .VBP(A_VBP),
                   .CW(4), .HS_POL(1'b1), .VS_POL(1'b1)) u_a (
    .clk_25(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_a), .vsync(vs_a),
    .active(act_a), .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a),
    .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );

  vga_timing_gen #(.HVID(B_HVID), .HFP(B_HFP), .HS(B_HS), .HBP(B_HBP),
                   .VVID(B_VVID), .VFP(B_VFP), .VS(B_VS), .VBP(B_VBP),
                   .CW(4), .HS_POL(1'b0), .VS_POL(1'b0)) u_b (
    .clk_25(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_b), .vsync(vs_b),
    .active(act_b), .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b),
    .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );

  vga_timing_gen u_d (
    .clk_25(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_d), .vsync(vs_d),
    .active(act_d), .pixel_x(px_d), .pixel_y(py_d), .line_start(ls_d),
    .frame_start(fs_d)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_d)
`endif
  );

  // Raster position is simply the number of enabled edges since reset,
  // folded into (x, y) by the line and frame lengths.
  function automatic obs_t model(input int hvid, input int hfp, input int hsw,
                                 input int hbp, input int vvid, input int vfp,
                                 input int vsw, input int vbp, input bit hpol,
                                 input bit vpol, input int cnt, input bit pls);
    obs_t o;
    int hc, vc, x, y;
    hc = hvid + hfp + hsw + hbp;
    vc = vvid + vfp + vsw + vbp;
    x = cnt % hc;
    y = (cnt / hc) % vc;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = (x >= hvid + hfp && x < hvid + hfp + hsw) ? hpol : ~hpol;
    o.vs  = (y >= vvid + vfp && y < vvid + vfp + vsw) ? vpol : ~vpol;
    o.act = (x < hvid) && (y < vvid);
    o.ls  = pls && (x == 0);
    o.fs  = pls && (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t mk(input int x, input int y, input bit hs, input bit vs,
                              input bit act, input bit ls, input bit fs);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.hs = hs; o.vs = vs;
    o.act = act; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               name, got.x, got.y, got.hs, got.vs, got.act, got.ls, got.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs);
    else
      passed++;
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp)
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else
      passed++;
  endtask

  function automatic obs_t got_a();
    return {10'(px_a), 10'(py_a), hs_a, vs_a, act_a, ls_a, fs_a};
  endfunction

  task automatic step(input bit r, input bit e);
    rst = r;
    pix_en = e;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) n++;
    pulse = !r && e;
    chk("model_a", got_a(),
        model(A_HVID, A_HFP, A_HS, A_HBP, A_VVID, A_VFP, A_VS, A_VBP, 1'b1, 1'b1, n, pulse));
    chk("model_b", {10'(px_b), 10'(py_b), hs_b, vs_b, act_b, ls_b, fs_b},
        model(B_HVID, B_HFP, B_HS, B_HBP, B_VVID, B_VFP, B_VS, B_VBP, 1'b0, 1'b0, n, pulse));
    chk("model_d", {px_d, py_d, hs_d, vs_d, act_d, ls_d, fs_d},
        model(640, 16, 96, 48, 480, 10, 2, 29, 1'b1, 1'b1, n, pulse));
`ifdef VGA_FRAME_COUNT_EN
    chk_int("frame_count_a", int'(fc_a), (n / 135) % 65536);
`endif
  endtask

  vec_t tbl[18];
  int hs_cnt, hs_first, ls_first, ls_second, vs_cnt, act_cnt, fs_first, fs_second, fs_cnt;

  initial begin
    // Config A: line 15 clocks, hsync x=10..12, vsync y=6..7, frame 135 clocks
    tbl[0]  = '{1'b1, 1'b1, 3,   mk(0,  0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 1,   mk(1,  0, 0, 0, 1, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 2,   mk(1,  0, 0, 0, 1, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 7,   mk(8,  0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b1, 2,   mk(10, 0, 1, 0, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b1, 2,   mk(12, 0, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 1,   mk(13, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b1, 1,   mk(14, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1'b0, 1'b1, 1,   mk(0,  1, 0, 0, 1, 1, 0)};
    tbl[9]  = '{1'b0, 1'b0, 1,   mk(0,  1, 0, 0, 1, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, 1,   mk(1,  1, 0, 0, 1, 0, 0)};
    tbl[11] = '{1'b0, 1'b1, 74,  mk(0,  6, 0, 1, 0, 1, 0)};
    tbl[12] = '{1'b0, 1'b1, 30,  mk(0,  8, 0, 0, 0, 1, 0)};
    tbl[13] = '{1'b0, 1'b1, 14,  mk(14, 8, 0, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, 1'b1, 1,   mk(0,  0, 0, 0, 1, 1, 1)};
    tbl[15] = '{1'b0, 1'b0, 1,   mk(0,  0, 0, 0, 1, 0, 0)};
    tbl[16] = '{1'b0, 1'b1, 100, mk(10, 6, 1, 1, 0, 0, 0)};
    tbl[17] = '{1'b1, 1'b1, 1,   mk(0,  0, 0, 0, 1, 0, 0)};

    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].r, tbl[i].e);
      chk($sformatf("table[%0d]", i), got_a(), tbl[i].exp);
    end

    // Continuous enable from reset: default raster line, small raster frame
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    hs_cnt = 0; hs_first = -1; ls_first = -1; ls_second = -1;
    vs_cnt = 0; act_cnt = 0; fs_first = -1; fs_second = -1;
    for (int i = 1; i <= 1600; i++) begin
      step(1'b0, 1'b1);
      if (i <= 800 && hs_d) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (ls_d) begin
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (i <= 135 && vs_a) vs_cnt++;
      if (i <= 135 && act_a) act_cnt++;
      if (fs_a) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    chk_int("d_hsync_width", hs_cnt, 96);
    chk_int("d_hsync_first_x", hs_first, 656);
    chk_int("d_line_start_1", ls_first, 800);
    chk_int("d_line_start_2", ls_second, 1600);
    chk_int("a_vsync_clocks", vs_cnt, 30);
    chk_int("a_active_clocks", act_cnt, 40);
    chk_int("a_frame_start_1", fs_first, 135);
    chk_int("a_frame_period", fs_second - fs_first, 135);

    // Half-rate enable: two frames of enabled edges give exactly two pulses
    step(1'b1, 1'b1);
    fs_cnt = 0;
    for (int i = 0; i < 540; i++) begin
      step(1'b0, (i % 2) == 0);
      if (fs_a) fs_cnt++;
    end
    chk_int("a_toggle_frame_pulses", fs_cnt, 2);

    // Randomised enable with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom % 300) == 0, ($urandom % 4) != 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
